// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: UART transmitter, start + DATA_WIDTH data (LSB first)
// + optional parity + 1/2 stop bits, CLKS_PER_BIT clocks per bit.
// Ports: clk, rst (async, active high), p_data/data_valid/ready handshake,
// parity_enable, parity_type (0 even, 1 odd), stop_bits (0 one, 1 two),
// tx_out (serial line, idles high), busy.
// Optional input FIFO of FIFO_DEPTH entries: define UART_TX_FIFO_EN.
module uart_tx_frame_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  ready,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  stop_bits,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
    $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int EW = DATA_WIDTH + 3;

  localparam logic [CW-1:0] BAUD_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE = CW'(1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
      CLKS_PER_BIT < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_param
    $error("uart_tx_frame_engine: illegal parameter");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  ptype_w;

  logic          baud_wrap;
  logic          last_cycle;
  logic          take;
  logic          src_valid;
  logic [EW-1:0] src_word;

  assign baud_wrap = (baud_q == BAUD_LAST);

  // In STOP, bit_q counts stop bits: 0 first, 1 second.
  assign last_cycle = (state_q == S_STOP) &&
                      baud_wrap &&
                      (!stop2_q || bit_q == BIT_ONE);

  // A new frame starts from IDLE or directly on the edge
  // that ends the final stop bit (no idle gap).
  assign take = src_valid &&
                ((state_q == S_IDLE) || last_cycle);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL =
    (AW+1)'(FIFO_DEPTH);

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full;
  logic          push;

  // Full is judged on the registered count, so a push to a
  // full FIFO is refused even when a pop shares the edge.
  assign full      = (cnt_q == CNT_FULL);
  assign push      = data_valid && !full;
  assign ready     = !full;
  assign src_valid = (cnt_q != '0);
  assign src_word  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PTR_ONE;
    if (take) rd_d = rd_q + PTR_ONE;
    unique case ({push, take})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {stop_bits, parity_type,
                      parity_enable, p_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign src_valid = data_valid;
  assign src_word  = {stop_bits, parity_type,
                      parity_enable, p_data};
  assign ready     = (state_q == S_IDLE) || last_cycle;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pen_d   = pen_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    ptype_w = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_wrap ? '0 : baud_q + BAUD_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_START: begin
        if (baud_wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_q == BIT_LAST) begin
            state_d = pen_q ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d  = bit_q + BIT_ONE;
            data_d = data_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (last_cycle) begin
          state_d = S_IDLE;
          bit_d   = '0;
        end else if (baud_wrap) begin
          bit_d = BIT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame controls are latched here and held for the
    // whole frame regardless of the input pins.
    if (take) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      {stop2_d, ptype_w, pen_d, data_d} = src_word;
      par_d   = (^data_d) ^ ptype_w;
    end
  end

  // Line level follows the next state so tx_out is a flop
  // that changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
`ifdef UART_TX_FIFO_EN
    busy_d = (state_d != S_IDLE) || (cnt_d != '0);
`else
    busy_d = (state_d != S_IDLE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine: bench for uart_tx_frame_engine.
// Frames are modelled as per-cycle line timelines.
module tb_uart_tx_frame_engine;

  localparam int DW    = 8;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk, rst, dv, pen, pt, sb;
  logic          rdy, txo, bsy;
  logic [DW-1:0] pd;

  uart_tx_frame_engine #(
    .DATA_WIDTH(DW),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p_data(pd),
    .data_valid(dv),
    .ready(rdy),
    .parity_enable(pen),
    .parity_type(pt),
    .stop_bits(sb),
    .tx_out(txo),
    .busy(bsy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  typedef struct {
    int          acc;
    int          start;
    int          endc;
    logic [15:0] bits;
  } frame_t;

  typedef struct {
    logic [7:0] w;
    logic       e;
    logic       t;
    logic       s;
    logic       mid;
    int         len;
  } vec_t;

  frame_t fq[$];
  vec_t   vt[8];

  int cyc, checks, errors;
  int busy_low, ready_hi;
  int probe_a, probe_b, pa, pb;
  bit last_acc;

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  function automatic void add_frame(
    input int acc, input logic [DW-1:0] w,
    input logic e, input logic t, input logic s);
    frame_t f;
    int n;
    f.bits = '0;
    n = 1;
    for (int i = 0; i < DW; i++) begin
      f.bits[n] = w[i];
      n++;
    end
    if (e) begin
      f.bits[n] = (^w) ^ t;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (s) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.acc = acc;
`ifdef UART_TX_FIFO_EN
    f.start = acc + 1;
    if (fq.size() > 0 && fq[$].endc > f.start)
      f.start = fq[$].endc;
`else
    f.start = acc;
`endif
    f.endc = f.start + n * CPB;
    fq.push_back(f);
  endfunction

  function automatic int tx_exp(input int c);
    int r;
    r = 1;
    foreach (fq[i])
      if (c >= fq[i].start && c < fq[i].endc)
        r = int'(fq[i].bits[(c - fq[i].start) / CPB]);
    return r;
  endfunction

  function automatic int busy_exp(input int c);
    int r;
    r = 0;
    foreach (fq[i])
      if (c >= fq[i].acc && c < fq[i].endc) r = 1;
    return r;
  endfunction

  function automatic int ready_exp(input int c);
    int n;
    n = 0;
`ifdef UART_TX_FIFO_EN
    foreach (fq[i])
      if (c >= fq[i].acc && c < fq[i].start) n++;
    return (n < DEPTH) ? 1 : 0;
`else
    foreach (fq[i])
      if (c >= fq[i].start && c < fq[i].endc - 1) n++;
    return (n == 0) ? 1 : 0;
`endif
  endfunction

  task automatic tick();
    bit acc;
    acc = dv && (ready_exp(cyc) != 0);
    @(posedge clk);
    cyc++;
    last_acc = acc;
    if (acc) add_frame(cyc, pd, pen, pt, sb);
    #1;
    chk("tx_out", int'(txo), tx_exp(cyc));
    chk("busy", int'(bsy), busy_exp(cyc));
    chk("ready", int'(rdy), ready_exp(cyc));
    if (!bsy) busy_low++;
    if (rdy) ready_hi++;
    if (cyc == probe_a) pa = int'(txo);
    if (cyc == probe_b) pb = int'(txo);
  endtask

  task automatic send(input logic [DW-1:0] w,
                      input logic e, input logic t,
                      input logic s);
    int n;
    n = 0;
    dv = 1'b1; pd = w; pen = e; pt = t; sb = s;
    last_acc = 1'b0;
    while (!last_acc && n < 3000) begin
      tick();
      n++;
    end
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout word %0h", w);
    end
    dv  = 1'b0;
    pd  = DW'($urandom);
    pen = 1'($urandom_range(0, 1));
    pt  = 1'($urandom_range(0, 1));
    sb  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_exp(cyc) != 0 && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout at cycle %0d", cyc);
    end
  endtask

  task automatic measure(input int a,
                         output int blen, output int midv);
    int n, mid;
    n = 0;
    mid = a + LAT + CPB * (1 + DW) + CPB / 2;
    blen = bsy ? 1 : 0;
    midv = -1;
    while (bsy && n < 1000) begin
      tick();
      n++;
      if (bsy) blen++;
      if (cyc == mid) midv = int'(txo);
    end
  endtask

  task automatic mid_reset(input logic [DW-1:0] w,
                           input int fbit, input int lvl);
    int n, tgt;
    send(w, 1'b0, 1'b0, 1'b0);
    tgt = fq[$].start + CPB * fbit + 5;
    n = 0;
    while (cyc < tgt && n < 1000) begin
      tick();
      n++;
    end
    chk("pre_reset_level", int'(txo), lvl);
    rst = 1'b1;
    #1;
    chk("midrst_tx", int'(txo), 1);
    chk("midrst_busy", int'(bsy), 0);
    chk("midrst_ready", int'(rdy), 1);
    fq.delete();
    dv = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1 rst = 1'b0;
  endtask

  int a, blen, midv, n;
`ifdef UART_TX_FIFO_EN
  int e0;
`endif

  initial begin
    vt[0] = '{8'hD8, 1'b0, 1'b0, 1'b0, 1'b1, 160};
    vt[1] = '{8'hDF, 1'b1, 1'b1, 1'b0, 1'b0, 176};
    vt[2] = '{8'hAC, 1'b1, 1'b0, 1'b1, 1'b0, 192};
    vt[3] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 176};
    vt[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 192};
    vt[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 176};
    vt[6] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 176};
    vt[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 192};

    cyc = 0; checks = 0; errors = 0;
    busy_low = 0; ready_hi = 0;
    probe_a = -1; probe_b = -1; pa = -1; pb = -1;
    rst = 1'b1; dv = 1'b0; pd = '0;
    pen = 1'b0; pt = 1'b0; sb = 1'b0;
    #1;
    chk("reset_tx", int'(txo), 1);
    chk("reset_busy", int'(bsy), 0);
    chk("reset_ready", int'(rdy), 1);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1 rst = 1'b0;

    foreach (vt[i]) begin
      send(vt[i].w, vt[i].e, vt[i].t, vt[i].s);
      a = cyc;
      measure(a, blen, midv);
      chk("frame_len", blen, vt[i].len + LAT);
      chk("bit9_level", midv, int'(vt[i].mid));
      wait_idle();
    end

    send(8'h55, 1'b0, 1'b0, 1'b0);
    probe_a = fq[$].endc;
    probe_b = probe_a - 1;
    busy_low = 0;
    send(8'hA3, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (cyc < fq[$].endc - 1 && n < 1000) begin
      tick();
      n++;
    end
    chk("b2b_busy_gap", busy_low, 0);
    chk("b2b_next_start", pa, 0);
    chk("b2b_stop_before", pb, 1);
    probe_a = -1; probe_b = -1;
    wait_idle();

    mid_reset(8'h3C, 4, 1);
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    a = cyc;
    measure(a, blen, midv);
    chk("post_rst_len", blen, 160 + LAT);
    chk("post_rst_stop", midv, 1);
    wait_idle();

    mid_reset(8'h3C, 1, 0);
    send(8'hC5, 1'b1, 1'b1, 1'b1);
    wait_idle();

`ifdef UART_TX_FIFO_EN
    send(8'h99, 1'b0, 1'b0, 1'b1);
    e0 = fq[$].endc;
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b1, 1'b1);
    send(8'h33, 1'b0, 1'b0, 1'b1);
    send(8'h44, 1'b1, 1'b1, 1'b0);
    chk("fifo_full_ready", int'(rdy), 0);
    ready_hi = 0;
    send(8'h55, 1'b0, 1'b0, 1'b0);
    chk("fifo_ready_window", ready_hi, 1);
    chk("fifo_55_after_pop", (cyc > e0) ? 1 : 0, 1);
    wait_idle();
`endif

    for (int i = 0; i < 3000; i++) begin
      dv  = ($urandom_range(0, 7) == 0);
      pd  = DW'($urandom);
      pen = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      sb  = 1'($urandom_range(0, 1));
      tick();
    end
    dv = 1'b0;
    wait_idle();
    tick();
    chk("final_idle_busy", int'(bsy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
